// File: rtl/rr_arbiter_param.sv
// rr_arbiter_param: N-way round-robin arbiter with a registered one-hot grant,
// a valid/ready beat handshake toward the sink, and a per-tenure burst limit of
// HOLD_MAX accepted beats.
//
// Optional build macro RR_ARB_LOCK_EN adds lock_i. While lock_i is high the
// burst limit does not end a tenure; a dropped request still does.

// Per-requester lane: splits one request into the two rotation segments.
// The first segment is indices ptr down to 0. The second is N-1 down to ptr+1.
module rr_arb_lane #(
   parameter int IDX_W = 2,
   parameter int K     = 0
) (
   input  logic             req,
   input  logic [IDX_W-1:0] ptr,
   output logic             seg_first,
   output logic             seg_second
);
   localparam logic [IDX_W-1:0] KI = IDX_W'(K);

   assign seg_first  = req & (KI <= ptr);
   assign seg_second = req & (KI >  ptr);
endmodule

module rr_arbiter_param #(
   parameter int N        = 4,
   parameter int HOLD_MAX = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N-1:0]         req_i,
   input  logic                 ready_i,
   output logic [N-1:0]         gnt_o,
   output logic                 gnt_valid_o,
   output logic [$clog2(N)-1:0] gnt_idx_o
`ifdef RR_ARB_LOCK_EN
   ,
   input  logic                 lock_i
`endif
);
   localparam int IDX_W = $clog2(N);
   localparam int CNT_W = $clog2(HOLD_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);
   localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(N - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t           state;
   logic [IDX_W-1:0] ptr;
   logic [CNT_W-1:0] beat_cnt;

   logic [N-1:0]     seg_first, seg_second, seg_pick;
   logic [IDX_W-1:0] win_idx, ptr_nxt;
   logic [N-1:0]     win_oh;
   logic             win_any;
   logic             owner_req, fire, at_limit, limit_rel, release_now;

   // Segment each request against the rotation pointer.
   for (genvar k = 0; k < N; k++) begin : g_lane
      rr_arb_lane #(.IDX_W(IDX_W), .K(k)) u_lane (
         .req        (req_i[k]),
         .ptr        (ptr),
         .seg_first  (seg_first[k]),
         .seg_second (seg_second[k])
      );
   end

   // Winner: the highest requesting index in the first segment, otherwise the
   // highest in the second. This gives a descending search from ptr that wraps.
   always_comb begin
      seg_pick = (|seg_first) ? seg_first : seg_second;
      win_idx  = '0;
      for (int k = 0; k < N; k++)
         if (seg_pick[k]) win_idx = IDX_W'(k);
   end

   assign win_any = |req_i;
   assign win_oh  = {{(N-1){1'b0}}, 1'b1} << win_idx;
   // After granting k, the search restarts at k-1. The new owner is then the
   // last index checked on the next arbitration.
   assign ptr_nxt = (win_idx == '0) ? IDX_TOP : (win_idx - 1'b1);

   // Beat accounting and tenure release causes.
   assign owner_req = |(req_i & gnt_o);
   assign fire      = gnt_valid_o & ready_i & owner_req;
   assign at_limit  = (beat_cnt == CNT_LAST);
`ifdef RR_ARB_LOCK_EN
   assign limit_rel = fire & at_limit & ~lock_i;
`else
   assign limit_rel = fire & at_limit;
`endif
   assign release_now = ~owner_req | limit_rel;

   // Grant FSM. On release it re-arbitrates in the same cycle, so there is no
   // idle bubble between owners.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         gnt_o       <= '0;
         gnt_valid_o <= 1'b0;
         gnt_idx_o   <= '0;
         ptr         <= IDX_TOP;
         beat_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_any) begin
                  state       <= GRANT;
                  gnt_o       <= win_oh;
                  gnt_valid_o <= 1'b1;
                  gnt_idx_o   <= win_idx;
                  ptr         <= ptr_nxt;
                  beat_cnt    <= '0;
               end
            end
            GRANT: begin
               if (release_now) begin
                  if (win_any) begin
                     gnt_o       <= win_oh;
                     gnt_valid_o <= 1'b1;
                     gnt_idx_o   <= win_idx;
                     ptr         <= ptr_nxt;
                  end else begin
                     state       <= IDLE;
                     gnt_o       <= '0;
                     gnt_valid_o <= 1'b0;
                     gnt_idx_o   <= '0;
                  end
                  beat_cnt <= '0;
               end else if (fire && !at_limit) begin
                  // A locked owner at the limit keeps its count saturated.
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
            default: begin
               state       <= IDLE;
               gnt_o       <= '0;
               gnt_valid_o <= 1'b0;
               gnt_idx_o   <= '0;
               beat_cnt    <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_rr_arbiter_param.sv
// Directed bench for rr_arbiter_param. It uses three instances: HOLD_MAX=1, 3 and 2.
// Expected grants are queued when stimulus is driven and checked after the edge.
module tb_rr_arbiter_param;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic [3:0] req_a, req_b, req_c;
   logic       rdy_a, rdy_b, rdy_c;
   logic [3:0] gnt_a, gnt_b, gnt_c;
   logic       vld_a, vld_b, vld_c;
   logic [1:0] idx_a, idx_b, idx_c;
`ifdef RR_ARB_LOCK_EN
   logic       lock_c;
`endif

   rr_arbiter_param #(.N(4), .HOLD_MAX(1)) u_a (
      .clk(clk), .reset_n(reset_n), .req_i(req_a), .ready_i(rdy_a),
      .gnt_o(gnt_a), .gnt_valid_o(vld_a), .gnt_idx_o(idx_a)
`ifdef RR_ARB_LOCK_EN
      , .lock_i(1'b0)
`endif
   );

   rr_arbiter_param #(.N(4), .HOLD_MAX(3)) u_b (
      .clk(clk), .reset_n(reset_n), .req_i(req_b), .ready_i(rdy_b),
      .gnt_o(gnt_b), .gnt_valid_o(vld_b), .gnt_idx_o(idx_b)
`ifdef RR_ARB_LOCK_EN
      , .lock_i(1'b0)
`endif
   );

   rr_arbiter_param #(.N(4), .HOLD_MAX(2)) u_c (
      .clk(clk), .reset_n(reset_n), .req_i(req_c), .ready_i(rdy_c),
      .gnt_o(gnt_c), .gnt_valid_o(vld_c), .gnt_idx_o(idx_c)
`ifdef RR_ARB_LOCK_EN
      , .lock_i(lock_c)
`endif
   );

   typedef struct {
      int         dut;
      logic [3:0] gnt;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic expect_gnt(input int d, input logic [3:0] g, input string tag);
      exp_t e;
      e.dut = d; e.gnt = g; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic check_all();
      exp_t       e;
      logic [3:0] og;
      logic       ov, ev;
      logic [1:0] oi, ei;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.dut)
            0:       begin og = gnt_a; ov = vld_a; oi = idx_a; end
            1:       begin og = gnt_b; ov = vld_b; oi = idx_b; end
            default: begin og = gnt_c; ov = vld_c; oi = idx_c; end
         endcase
         ev = |e.gnt;
         ei = 2'd0;
         for (int k = 0; k < 4; k++) if (e.gnt[k]) ei = 2'(k);
         n_vec++;
         assert (og === e.gnt) else begin
            n_err++;
            $error("FAIL %s gnt observed=%b expected=%b", e.tag, og, e.gnt);
         end
         n_vec++;
         assert (ov === ev) else begin
            n_err++;
            $error("FAIL %s valid observed=%b expected=%b", e.tag, ov, ev);
         end
         n_vec++;
         assert (oi === ei) else begin
            n_err++;
            $error("FAIL %s idx observed=%0d expected=%0d", e.tag, oi, ei);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      reset_n = 1'b0;
      req_a = '0; req_b = '0; req_c = '0;
      rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
`ifdef RR_ARB_LOCK_EN
      lock_c = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      expect_gnt(0, 4'b0000, "rst_a");
      expect_gnt(1, 4'b0000, "rst_b");
      expect_gnt(2, 4'b0000, "rst_c");
      check_all();
      reset_n = 1'b1;
      expect_gnt(0, 4'b0000, "idle_a"); tick();

      // Rotation with HOLD_MAX=1, starting from the highest index.
      req_a = 4'b1111; rdy_a = 1'b1;
      expect_gnt(0, 4'b1000, "t1_0"); tick();
      expect_gnt(0, 4'b0100, "t1_1"); tick();
      expect_gnt(0, 4'b0010, "t1_2"); tick();
      expect_gnt(0, 4'b0001, "t1_3"); tick();
      expect_gnt(0, 4'b1000, "t1_4"); tick();
      req_a = 4'b0000;
      expect_gnt(0, 4'b0000, "t1_idle"); tick();

      // HOLD_MAX=3 with two requesters: three beats each, no gap.
      req_b = 4'b1010; rdy_b = 1'b1;
      for (int i = 0; i < 3; i++) begin expect_gnt(1, 4'b1000, "t2_a"); tick(); end
      for (int i = 0; i < 3; i++) begin expect_gnt(1, 4'b0010, "t2_b"); tick(); end
      for (int i = 0; i < 3; i++) begin expect_gnt(1, 4'b1000, "t2_c"); tick(); end
      req_b = 4'b0000;
      expect_gnt(1, 4'b0000, "t2_idle"); tick();

      // Stalls are not counted. A sole requester is regranted with a fresh count.
      req_b = 4'b0100; rdy_b = 1'b1;
      expect_gnt(1, 4'b0100, "t3_0"); tick();
      expect_gnt(1, 4'b0100, "t3_1"); tick();
      rdy_b = 1'b0;
      expect_gnt(1, 4'b0100, "t3_s0"); tick();
      expect_gnt(1, 4'b0100, "t3_s1"); tick();
      rdy_b = 1'b1;
      expect_gnt(1, 4'b0100, "t3_2"); tick();
      expect_gnt(1, 4'b0100, "t3_regrant"); tick();
      req_b = 4'b0110;
      expect_gnt(1, 4'b0100, "t3_r1"); tick();
      expect_gnt(1, 4'b0100, "t3_r2"); tick();
      expect_gnt(1, 4'b0010, "t3_hand"); tick();

      // Owner drops its request: a pending requester is granted next, otherwise the arbiter goes idle.
      req_b = 4'b0001;
      expect_gnt(1, 4'b0001, "t4_drop"); tick();
      req_b = 4'b0000;
      expect_gnt(1, 4'b0000, "t4_idle"); tick();

      // HOLD_MAX=2 with a stall cycle in the first tenure.
      req_c = 4'b1100; rdy_c = 1'b1;
      expect_gnt(2, 4'b1000, "tc_0"); tick();
      rdy_c = 1'b0;
      expect_gnt(2, 4'b1000, "tc_stall"); tick();
      rdy_c = 1'b1;
      expect_gnt(2, 4'b1000, "tc_1"); tick();
      expect_gnt(2, 4'b0100, "tc_2"); tick();
      expect_gnt(2, 4'b0100, "tc_3"); tick();
      expect_gnt(2, 4'b1000, "tc_4"); tick();
      req_c = 4'b0000;
      expect_gnt(2, 4'b0000, "tc_idle"); tick();

      // Pointer survives idle. Then assert reset mid-tenure.
      req_a = 4'b1111;
      expect_gnt(0, 4'b0100, "t5_0"); tick();
      expect_gnt(0, 4'b0010, "t5_1"); tick();
      reset_n = 1'b0;
      #1;
      expect_gnt(0, 4'b0000, "t5_rst_a");
      expect_gnt(1, 4'b0000, "t5_rst_b");
      expect_gnt(2, 4'b0000, "t5_rst_c");
      check_all();
      #2;
      reset_n = 1'b1;
      expect_gnt(0, 4'b1000, "t5_first");
      expect_gnt(1, 4'b0000, "t5_b_idle");
      expect_gnt(2, 4'b0000, "t5_c_idle");
      tick();
      req_a = 4'b0000;
      expect_gnt(0, 4'b0000, "t5_idle"); tick();

`ifdef RR_ARB_LOCK_EN
      // Lock suppresses the burst limit. The first fire after unlock hands over.
      req_c = 4'b1100; rdy_c = 1'b1; lock_c = 1'b1;
      for (int i = 0; i < 6; i++) begin expect_gnt(2, 4'b1000, "t6_lock"); tick(); end
      lock_c = 1'b0;
      expect_gnt(2, 4'b0100, "t6_hand"); tick();
      expect_gnt(2, 4'b0100, "t6_b1"); tick();
      expect_gnt(2, 4'b1000, "t6_back"); tick();
      req_c = 4'b0000;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
